// File: rtl/sync_pulse_toggle_src_pkg.sv
// Shared types and helpers for the pulse-to-toggle CDC launcher.
// Holds the FSM state encoding and the pending-counter saturation value.
package sync_pulse_toggle_src_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // All-ones value of a counter of the given width (saturation point).
    function automatic logic [31:0] cntFull(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_ack_2ff.sv
// Generic two-flop synchronizer into sCLK; the first stage absorbs metastability.
// The reset value is a parameter so it can track the far side's initial level.
module sync_ack_2ff #(
    parameter logic init = 1'b0
) (
    input  logic sCLK,
    input  logic sRST,
    input  logic dIN,
    output logic sOUT
);

    logic stage1_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge sCLK or negedge sRST) begin
        if (!sRST) begin
            stage1_r <= init;
            sOUT     <= init;
        end else begin
            stage1_r <= dIN;
            sOUT     <= stage1_r;
        end
    end

endmodule

// File: rtl/sync_pulse_toggle_src.sv
// Source side of a toggle-based pulse crossing: queues event pulses and
// launches each as a request toggle, waiting for the matching ack toggle.
module sync_pulse_toggle_src
    import sync_pulse_toggle_src_pkg::*;
#(
    parameter logic        init      = 1'b0,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 sCLK,
    input  logic                 sRST,
    input  logic                 sPULSE_IN,
    input  logic                 sCLR_OVF,
    input  logic                 dACK_IN,
    output logic                 sREQ_OUT,
    output logic                 sEN_OUT,
    output logic                 sRDY,
    output logic [CNT_WIDTH-1:0] sPENDING,
    output logic                 sOVF
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(cntFull(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

    state_t               state_r;
    logic                 ackS2_s;
    logic                 launch_s;
    logic                 ovfSet_s;
    logic [CNT_WIDTH-1:0] cntNext_s;

    sync_ack_2ff #(
        .init (init)
    ) u_ackSync (
        .sCLK (sCLK),
        .sRST (sRST),
        .dIN  (dACK_IN),
        .sOUT (ackS2_s)
    );

    // Launch decision and next pending count; a pulse that coincides with a
    // launch either replaces the counter's event or is itself launched.
    always_comb begin
        launch_s  = 1'b0;
        ovfSet_s  = 1'b0;
        cntNext_s = sPENDING;
        if (state_r == IDLE) begin
            launch_s = sPULSE_IN || (sPENDING != CNT_ZERO);
        end else begin
            launch_s = 1'b0;
        end
        if (sPULSE_IN && !launch_s) begin
            if (sPENDING == CNT_FULL) begin
                ovfSet_s = 1'b1;
            end else begin
                cntNext_s = sPENDING + CNT_ONE;
            end
        end else if (launch_s && !sPULSE_IN) begin
            cntNext_s = sPENDING - CNT_ONE;
        end else begin
            cntNext_s = sPENDING;
        end
    end

    // Handshake FSM with registered request, load strobe, counter and flag.
    always_ff @(posedge sCLK or negedge sRST) begin
        if (!sRST) begin
            state_r  <= IDLE;
            sREQ_OUT <= init;
            sEN_OUT  <= 1'b0;
            sPENDING <= CNT_ZERO;
            sOVF     <= 1'b0;
        end else begin
            sEN_OUT  <= 1'b0;
            sPENDING <= cntNext_s;
            if (ovfSet_s) begin
                sOVF <= 1'b1;
            end else if (sCLR_OVF) begin
                sOVF <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        sREQ_OUT <= ~sREQ_OUT;
                        sEN_OUT  <= 1'b1;
                        state_r  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ackS2_s == sREQ_OUT) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign sRDY = (state_r == IDLE) && (sPENDING == CNT_ZERO);

endmodule
